// File: rtl/tworeg_seq_gen_if.sv
// Stimulus-generator bus: burst request/parameters in, A/B pair, framing and prediction out.
// Generator side is master; the consumer or bench driving start is slave.
interface tworeg_seq_gen_if;
  logic       start;
  logic [3:0] run_len;
  logic [3:0] repeat_cnt;
  logic       A;
  logic       B;
  logic       valid;
  logic       exp_out;
  logic       busy;
  logic       done;

  modport master (
    input  start, run_len, repeat_cnt,
    output A, B, valid, exp_out, busy, done
  );

  modport slave (
    output start, run_len, repeat_cnt,
    input  A, B, valid, exp_out, busy, done
  );
endinterface

// File: rtl/tworeg_seq_gen.sv
// Two-register stimulus generator: bursts of matching A/B runs with an LFSR payload, plus exp_out prediction.
// All outputs registered; the first burst cycle follows the accepted start by one clock; start is ignored while busy.
module tworeg_seq_gen #(
  parameter logic [7:0]  SEED      = 8'hA5,
  parameter int unsigned MATCH_MIN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  tworeg_seq_gen_if.master        bus
);

  typedef enum logic [1:0] {IDLE, MATCH, BREAK, DONE} state_t;

  localparam logic [3:0] MATCH_MIN_W = 4'(MATCH_MIN);
  localparam logic [2:0] STREAK_MAX  = 3'(MATCH_MIN);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [3:0] run_len_q, run_len_d;
  logic [3:0] run_cnt_q, run_cnt_d;
  logic [3:0] rep_cnt_q, rep_cnt_d;
  logic [2:0] streak_q, streak_d;
  logic [3:0] streak_inc;
  logic       pair_eq;
  logic       a_q, a_d, b_q, b_d, valid_q, valid_d;
  logic       exp_q, exp_d, busy_q, busy_d, done_q, done_d;

  assign lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    run_len_d = run_len_q;
    run_cnt_d = run_cnt_q;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          run_len_d = bus.run_len;
          run_cnt_d = bus.run_len;
          // rep_cnt holds the runs still to go after the current one; 0 requests a single run
          rep_cnt_d = (bus.repeat_cnt == 4'd0) ? 4'd0 : bus.repeat_cnt - 4'd1;
          lfsr_d    = SEED;
          state_d   = (bus.run_len == 4'd0) ? BREAK : MATCH;
        end
      end
      MATCH: begin
        lfsr_d = lfsr_adv;
        if (run_cnt_q != 4'd0) run_cnt_d = run_cnt_q - 4'd1;
        if (run_cnt_q <= 4'd1) state_d = BREAK;
      end
      BREAK: begin
        lfsr_d = lfsr_adv;
        if (rep_cnt_q != 4'd0) begin
          rep_cnt_d = rep_cnt_q - 4'd1;
          run_cnt_d = run_len_q;
          state_d   = (run_len_q == 4'd0) ? BREAK : MATCH;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q after the edge
    a_d     = 1'b0;
    b_d     = 1'b1;
    valid_d = 1'b0;
    case (state_d)
      MATCH: begin
        a_d     = lfsr_d[0];
        b_d     = lfsr_d[0];
        valid_d = 1'b1;
      end
      BREAK: begin
        a_d     = lfsr_d[0];
        b_d     = ~lfsr_d[0];
        valid_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

    pair_eq    = (a_q == b_q);
    streak_inc = {1'b0, streak_q} + 4'd1;
    exp_d      = pair_eq && (streak_inc >= MATCH_MIN_W);
    if (!pair_eq)                   streak_d = 3'd0;
    else if (streak_q >= STREAK_MAX) streak_d = streak_q;
    else                            streak_d = streak_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      run_len_q <= 4'd0;
      run_cnt_q <= 4'd0;
      rep_cnt_q <= 4'd0;
      streak_q  <= 3'd0;
      a_q       <= 1'b0;
      b_q       <= 1'b1;
      valid_q   <= 1'b0;
      exp_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      run_len_q <= run_len_d;
      run_cnt_q <= run_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      streak_q  <= streak_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      exp_q     <= exp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.valid   = valid_q;
  assign bus.exp_out = exp_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_tworeg_seq_gen.sv
// Directed and golden-model bench for tworeg_seq_gen (SEED=8'hA5, MATCH_MIN=4).
// Observed tuples are {A,B,valid,exp_out,busy,done}, sampled 1 time unit after each rising edge.
module tb_tworeg_seq_gen;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int         MM   = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  tworeg_seq_gen_if bus ();

  tworeg_seq_gen #(.SEED(SEED), .MATCH_MIN(MM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [5:0] obs();
    return {bus.A, bus.B, bus.valid, bus.exp_out, bus.busy, bus.done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    // reset and start on the same edge: reset wins
    reset = 1'b1;
    bus.start = 1'b1; bus.run_len = 4'd5; bus.repeat_cnt = 4'd1;
    tick(); tick();
    got = obs();
    n_checks++;
    if (got !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_state {A,B,valid,exp,busy,done}: got %b want %b", got, 6'b010000);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    got = obs();
    n_checks++;
    if (got !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_idle {A,B,valid,exp,busy,done}: got %b want %b", got, 6'b010000);
    end
  endtask

  task automatic test_single_run();
    logic [5:0] tbl [8];
    logic [5:0] got;
    tbl = '{6'b111010, 6'b001010, 6'b111010, 6'b001010,
            6'b001110, 6'b101110, 6'b010011, 6'b010000};
    bus.run_len = 4'd5; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.start = 1'b0;
      got = obs();
      n_checks++;
      if (got !== tbl[c-1]) begin
        n_fail++;
        $display("FAIL single_run cycle %0d {A,B,valid,exp,busy,done}: got %b want %b", c, got, tbl[c-1]);
      end
    end
  endtask

  task automatic test_two_runs();
    logic [5:0] tbl [10];
    logic [5:0] got;
    tbl = '{6'b111010, 6'b001010, 6'b111010, 6'b011010, 6'b001010,
            6'b111010, 6'b111010, 6'b101010, 6'b010011, 6'b010000};
    bus.run_len = 4'd3; bus.repeat_cnt = 4'd2; bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.start = 1'b0;
      got = obs();
      n_checks++;
      if (got !== tbl[c-1]) begin
        n_fail++;
        $display("FAIL two_runs cycle %0d {A,B,valid,exp,busy,done}: got %b want %b", c, got, tbl[c-1]);
      end
    end
  endtask

  task automatic test_zero_len();
    logic [5:0] tbl [3];
    logic [5:0] got;
    tbl = '{6'b101010, 6'b010011, 6'b010000};
    bus.run_len = 4'd0; bus.repeat_cnt = 4'd0; bus.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.start = 1'b0;
      got = obs();
      n_checks++;
      if (got !== tbl[c-1]) begin
        n_fail++;
        $display("FAIL zero_len cycle %0d {A,B,valid,exp,busy,done}: got %b want %b", c, got, tbl[c-1]);
      end
    end
  endtask

  task automatic test_start_held();
    logic [5:0] tbl [8];
    logic [5:0] got;
    tbl = '{6'b111010, 6'b001010, 6'b111010, 6'b001010,
            6'b011110, 6'b010011, 6'b010000, 6'b010000};
    bus.run_len = 4'd4; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      // parameter changes while busy must not reach the latched values
      if (c == 3) begin bus.run_len = 4'd1; bus.repeat_cnt = 4'd3; end
      if (c == 7) bus.start = 1'b0;
      got = obs();
      n_checks++;
      if (got !== tbl[c-1]) begin
        n_fail++;
        $display("FAIL start_held cycle %0d {A,B,valid,exp,busy,done}: got %b want %b", c, got, tbl[c-1]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [5:0] got, want;
    logic [7:0] l;
    bus.run_len = 4'd8; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      got = obs();
      n_checks++;
      if (got !== 6'b010000) begin
        n_fail++;
        $display("FAIL reset_mid idle %0d {A,B,valid,exp,busy,done}: got %b want %b", c, got, 6'b010000);
      end
      tick();
    end
    l = SEED;
    bus.run_len = 4'd8; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      bus.start = 1'b0;
      if (c <= 8)       want = {l[0], l[0], 1'b1, (c >= 5), 1'b1, 1'b0};
      else if (c == 9)  want = {l[0], ~l[0], 1'b1, 1'b1, 1'b1, 1'b0};
      else if (c == 10) want = 6'b010011;
      else              want = 6'b010000;
      l = lfsr_next(l);
      got = obs();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid rerun cycle %0d {A,B,valid,exp,busy,done}: got %b want %b", c, got, want);
      end
    end
  endtask

  task automatic test_golden();
    logic [7:0] hist, mask;
    logic       want;
    int         cyc;
    mask = 8'((9'd1 << MM) - 9'd1);
    for (int burst = 0; burst < 8; burst++) begin
      hist = 8'h00;
      bus.run_len    = 4'($urandom_range(0, 9));
      bus.repeat_cnt = 4'($urandom_range(0, 4));
      bus.start      = 1'b1;
      cyc = 0;
      do begin
        // detector: Out rises once the last MATCH_MIN presented pairs all matched
        hist = {hist[6:0], (bus.A === bus.B)};
        tick();
        bus.start = 1'b0;
        cyc++;
        want = ((hist & mask) == mask);
        n_checks++;
        if (bus.exp_out !== want) begin
          n_fail++;
          $display("FAIL golden burst %0d cycle %0d exp_out: got %b want %b", burst, cyc, bus.exp_out, want);
        end
      end while (bus.done !== 1'b1 && cyc < 300);
      if (bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL golden burst %0d timeout: done got %b want 1", burst, bus.done);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.run_len = 4'd0;
    bus.repeat_cnt = 4'd0;
    test_reset();
    test_single_run();
    test_two_runs();
    test_zero_len();
    test_start_held();
    test_reset_mid_burst();
    test_golden();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
